// File: rtl/crc_ci_stream_master_pkg.sv
// Shared definitions for the CRC custom-instruction stream master.
// Holds the FSM state encoding, the custom-instruction opcode values
// understood by the CRC slave, the kind of instruction currently in
// flight (used to pick the follow-on action when it completes) and the
// width of the done-timeout counter.
package crc_ci_pkg;

  localparam int TMO_W = 8;

  localparam logic [2:0] CI_N_INIT = 3'd0;
  localparam logic [2:0] CI_N_WR8  = 3'd1;
  localparam logic [2:0] CI_N_WR16 = 3'd2;
  localparam logic [2:0] CI_N_WR32 = 3'd3;
  localparam logic [2:0] CI_N_RD32 = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_CMD,
    ST_WAIT,
    ST_FINISH
  } state_e;

  // What the outstanding instruction is, so completion knows where to go.
  typedef enum logic [1:0] {
    OP_INIT,
    OP_WR,
    OP_WR_LAST,
    OP_RD
  } op_kind_e;

endpackage

// File: rtl/crc_ci_stream_master_if.sv
// Bundle of the byte-stream input, the custom-instruction initiator bus
// and the CRC result outputs of crc_ci_stream_master.
//   master : view of the stream master (consumes bytes, drives ci_*)
//   slave  : view of the environment (byte source, CRC slave, consumer)
// Ports:
//   in_data/in_valid/in_sop/in_eop -> master, in_ready <- master
//   ci_n/ci_dataa/ci_start/ci_clk_en <- master, ci_done/ci_result -> master
//   crc_value/crc_valid/crc_error/busy <- master
interface crc_ci_stream_master_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic        in_ready;
  logic [2:0]  ci_n;
  logic [31:0] ci_dataa;
  logic        ci_start;
  logic        ci_clk_en;
  logic        ci_done;
  logic [31:0] ci_result;
  logic [31:0] crc_value;
  logic        crc_valid;
  logic        crc_error;
  logic        busy;

  modport master (
    input  in_data, in_valid, in_sop, in_eop,
    output in_ready,
    output ci_n, ci_dataa, ci_start, ci_clk_en,
    input  ci_done, ci_result,
    output crc_value, crc_valid, crc_error, busy
  );

  modport slave (
    output in_data, in_valid, in_sop, in_eop,
    input  in_ready,
    input  ci_n, ci_dataa, ci_start, ci_clk_en,
    output ci_done, ci_result,
    input  crc_value, crc_valid, crc_error, busy
  );
endinterface

// File: rtl/crc_ci_stream_master_packer.sv
// Byte-lane packer for the CRC stream master.
// Collects stream bytes little-endian into a 32-bit word and decides when
// a write instruction is due (4th byte or end of packet) and which opcode
// it uses. A 3-byte tail is split into WR16 + WR8; the trailing byte is
// held as a pending second write. A single-byte packet (sop+eop) is also
// parked as a pending WR8 so it can follow the INIT directly.
// Ports:
//   load_i      : accept a start-of-packet byte (restarts the packet)
//   push_i      : accept a continuation byte
//   eop_i/byte_i: end-of-packet flag and data of the accepted byte
//   tail_take_i : the pending second write has been issued
//   flush_o     : the pushed byte completes a write (n_o, word_o)
//   last_o      : that write ends the packet with nothing pending after it
//   tail_pend_o/tail_word_o : pending WR8 and its operand
module crc_ci_packer
  import crc_ci_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic        push_i,
  input  logic        eop_i,
  input  logic [7:0]  byte_i,
  input  logic        tail_take_i,
  output logic        flush_o,
  output logic [2:0]  n_o,
  output logic [31:0] word_o,
  output logic        last_o,
  output logic        tail_pend_o,
  output logic [31:0] tail_word_o
);

  logic [23:0] lanes_q, lanes_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  tail_q, tail_d;
  logic        tail_pend_q, tail_pend_d;
  logic [31:0] merged;
  logic [2:0]  cnt_next;

  // Word as it would look with the incoming byte in its lane. Lanes above
  // the count are always zero because they are cleared on every flush.
  always_comb begin
    merged = {8'h00, lanes_q};
    merged[{cnt_q, 3'b000} +: 8] = byte_i;
    cnt_next = {1'b0, cnt_q} + 3'd1;
    flush_o = push_i & ((cnt_next == 3'd4) | eop_i);
    last_o = eop_i;
    case (cnt_next)
      3'd4: begin
        n_o = CI_N_WR32;
        word_o = merged;
      end
      3'd3: begin
        // bytes 0-1 now, byte 2 follows as a separate WR8
        n_o = CI_N_WR16;
        word_o = {16'h0000, merged[15:0]};
        last_o = 1'b0;
      end
      3'd2: begin
        n_o = CI_N_WR16;
        word_o = {16'h0000, merged[15:0]};
      end
      default: begin
        n_o = CI_N_WR8;
        word_o = {24'h000000, merged[7:0]};
      end
    endcase
  end

  always_comb begin
    lanes_d = lanes_q;
    cnt_d = cnt_q;
    tail_d = tail_q;
    tail_pend_d = tail_pend_q;
    if (tail_take_i) begin
      tail_pend_d = 1'b0;
    end
    if (load_i) begin
      tail_d = byte_i;
      if (eop_i) begin
        lanes_d = '0;
        cnt_d = '0;
        tail_pend_d = 1'b1;
      end else begin
        lanes_d = {16'h0000, byte_i};
        cnt_d = 2'd1;
        tail_pend_d = 1'b0;
      end
    end else if (push_i) begin
      if (flush_o) begin
        lanes_d = '0;
        cnt_d = '0;
        if (cnt_next == 3'd3) begin
          tail_d = merged[23:16];
          tail_pend_d = 1'b1;
        end
      end else begin
        lanes_d = merged[23:0];
        cnt_d = cnt_next[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lanes_q <= '0;
      cnt_q <= '0;
      tail_q <= '0;
      tail_pend_q <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      cnt_q <= cnt_d;
      tail_q <= tail_d;
      tail_pend_q <= tail_pend_d;
    end
  end

  assign tail_pend_o = tail_pend_q;
  assign tail_word_o = {24'h000000, tail_q};

endmodule

// File: rtl/crc_ci_stream_master.sv
// Nios II custom-instruction CRC initiator. Turns a byte packet stream
// into INIT / WR8 / WR16 / WR32 / READ instructions for a CRC slave and
// presents one 32-bit CRC per packet.
// Parameters:
//   DONE_TIMEOUT : max cycles ci_clk_en stays high without ci_done (1..255)
//   READ_N       : opcode used to read the result
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : stream input, custom-instruction bus and CRC outputs
module crc_ci_stream_master
  import crc_ci_pkg::*;
#(
  parameter int          DONE_TIMEOUT = 255,
  parameter int unsigned READ_N       = 4
) (
  input logic clk,
  input logic reset_n,
  crc_ci_stream_master_if.master bus
);

  localparam logic [2:0]       READ_OP   = 3'(READ_N);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(DONE_TIMEOUT);

  state_e            state_q, state_d;
  op_kind_e          op_q, op_d;
  logic [2:0]        ci_n_q, ci_n_d;
  logic [31:0]       ci_dataa_q, ci_dataa_d;
  logic [31:0]       crc_value_q, crc_value_d;
  logic              crc_error_q, crc_error_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [TMO_W-1:0]  elapsed;

  logic              pk_load, pk_push, pk_tail_take;
  logic              pk_flush, pk_last, pk_tail_pend;
  logic [2:0]        pk_n;
  logic [31:0]       pk_word, pk_tail_word;

  // Byte acceptance depends on state only, so the stream side never sees
  // a combinational path from in_valid to in_ready.
  assign pk_load = bus.in_valid & bus.in_sop &
                   ((state_q == ST_IDLE) | (state_q == ST_FILL));
  assign pk_push = bus.in_valid & ~bus.in_sop & (state_q == ST_FILL);

  crc_ci_packer u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (pk_load),
    .push_i      (pk_push),
    .eop_i       (bus.in_eop),
    .byte_i      (bus.in_data),
    .tail_take_i (pk_tail_take),
    .flush_o     (pk_flush),
    .n_o         (pk_n),
    .word_o      (pk_word),
    .last_o      (pk_last),
    .tail_pend_o (pk_tail_pend),
    .tail_word_o (pk_tail_word)
  );

  // elapsed counts ci_clk_en cycles of the current instruction including
  // this one; the abort fires when it reaches the limit without ci_done.
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    ci_n_d = ci_n_q;
    ci_dataa_d = ci_dataa_q;
    crc_value_d = crc_value_q;
    crc_error_d = 1'b0;
    tmo_d = tmo_q;
    pk_tail_take = 1'b0;
    elapsed = (state_q == ST_CMD) ? TMO_W'(1) : tmo_q + TMO_W'(1);

    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (pk_load) begin
          ci_n_d = CI_N_INIT;
          ci_dataa_d = '0;
          op_d = OP_INIT;
          state_d = ST_CMD;
        end else if (pk_flush) begin
          ci_n_d = pk_n;
          ci_dataa_d = pk_word;
          op_d = pk_last ? OP_WR_LAST : OP_WR;
          state_d = ST_CMD;
        end
      end
      ST_CMD, ST_WAIT: begin
        tmo_d = elapsed;
        if (bus.ci_done) begin
          case (op_q)
            OP_INIT, OP_WR: begin
              // A parked byte (sop+eop packet or 3-byte tail) goes out next.
              if (pk_tail_pend) begin
                pk_tail_take = 1'b1;
                ci_n_d = CI_N_WR8;
                ci_dataa_d = pk_tail_word;
                op_d = OP_WR_LAST;
                state_d = ST_CMD;
              end else begin
                state_d = ST_FILL;
              end
            end
            OP_WR_LAST: begin
              ci_n_d = READ_OP;
              ci_dataa_d = '0;
              op_d = OP_RD;
              state_d = ST_CMD;
            end
            default: begin
              crc_value_d = bus.ci_result;
              state_d = ST_FINISH;
            end
          endcase
        end else if (elapsed == TMO_LIMIT) begin
          crc_error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q <= OP_INIT;
      ci_n_q <= '0;
      ci_dataa_q <= '0;
      crc_value_q <= '0;
      crc_error_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      ci_n_q <= ci_n_d;
      ci_dataa_q <= ci_dataa_d;
      crc_value_q <= crc_value_d;
      crc_error_q <= crc_error_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE) | (state_q == ST_FILL);
  assign bus.ci_start  = (state_q == ST_CMD);
  assign bus.ci_clk_en = (state_q == ST_CMD) | (state_q == ST_WAIT);
  assign bus.ci_n      = ci_n_q;
  assign bus.ci_dataa  = ci_dataa_q;
  assign bus.crc_value = crc_value_q;
  assign bus.crc_valid = (state_q == ST_FINISH);
  assign bus.crc_error = crc_error_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crc_ci_stream_master.sv
// Self-checking bench for crc_ci_stream_master. A CRC-32 slave model
// answers the custom instructions; expected instructions and results are
// queued when stimulus is issued and popped by a monitor.
module tb_crc_ci_stream_master;
  import crc_ci_pkg::*;

  localparam int TMO = 16;

  typedef struct packed {
    logic [2:0]  n;
    logic [31:0] dataa;
  } op_t;

  typedef struct packed {
    logic        is_err;
    logic [31:0] value;
  } res_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  int unsigned valid_cyc = 0;
  int stall_all = -1;
  int stall_once = -1;
  op_t  exp_ops[$];
  res_t exp_res[$];

  crc_ci_stream_master_if bus();

  crc_ci_stream_master #(.DONE_TIMEOUT(TMO), .READ_N(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic pushOp(input logic [2:0] n, input logic [31:0] a);
    op_t o;
    o.n = n;
    o.dataa = a;
    exp_ops.push_back(o);
  endtask

  task automatic pushRes(input logic is_err, input logic [31:0] v);
    res_t r;
    r.is_err = is_err;
    r.value = v;
    exp_res.push_back(r);
  endtask

  // Hand-derived sequence for the "123456789" packet.
  task automatic expectDigits();
    pushOp(CI_N_INIT, 32'h0);
    pushOp(CI_N_WR32, 32'h34333231);
    pushOp(CI_N_WR32, 32'h38373635);
    pushOp(CI_N_WR8,  32'h00000039);
    pushOp(CI_N_RD32, 32'h0);
    pushRes(1'b0, 32'hCBF43926);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic sop, input logic eop);
    int guard;
    @(negedge clk);
    bus.in_data = d;
    bus.in_sop = sop;
    bus.in_eop = eop;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL in_ready_timeout: byte %h not accepted in 1000 cycles", d);
    end
    last_acc = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
  endtask

  task automatic sendDigits();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'h31 + 8'(i), i == 0, i == 8);
    end
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((exp_ops.size() != 0 || exp_res.size() != 0 || bus.busy) && guard < 3000);
    if (exp_ops.size() != 0 || exp_res.size() != 0 || bus.busy) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout: ops left %0d results left %0d busy %0b",
               exp_ops.size(), exp_res.size(), bus.busy);
    end
  endtask

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // CRC-32 custom-instruction slave: done with start for writes and INIT,
  // one cycle later for reads, unless a stall is requested.
  initial begin : slave
    int delay;
    int cnt;
    bit active;
    logic [2:0]  n;
    logic [31:0] a;
    logic [31:0] crc;
    active = 1'b0;
    delay = 0;
    cnt = 0;
    n = '0;
    a = '0;
    crc = 32'hFFFFFFFF;
    bus.ci_done = 1'b0;
    bus.ci_result = '0;
    forever begin
      @(negedge clk);
      bus.ci_done = 1'b0;
      if (!reset_n || !bus.ci_clk_en) begin
        active = 1'b0;
      end else if (bus.ci_start) begin
        active = 1'b1;
        cnt = 0;
        n = bus.ci_n;
        a = bus.ci_dataa;
        if (stall_once >= 0) begin
          delay = stall_once;
          stall_once = -1;
        end else if (stall_all >= 0) begin
          delay = stall_all;
        end else begin
          delay = (n == CI_N_RD32) ? 1 : 0;
        end
      end
      if (active) begin
        if (cnt == delay) begin
          case (n)
            CI_N_INIT: begin crc = 32'hFFFFFFFF; bus.ci_result = '0; end
            CI_N_WR8:  crc = crcByte(crc, a[7:0]);
            CI_N_WR16: crc = crcByte(crcByte(crc, a[7:0]), a[15:8]);
            CI_N_WR32: crc = crcByte(crcByte(crcByte(crcByte(crc, a[7:0]), a[15:8]), a[23:16]), a[31:24]);
            default:   bus.ci_result = ~crc;
          endcase
          bus.ci_done = 1'b1;
          active = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: pops expected instructions on ci_start and expected results
  // on crc_valid/crc_error, and watches instruction protocol.
  initial begin : monitor
    bit outstanding;
    op_t started;
    op_t e;
    res_t r;
    outstanding = 1'b0;
    started = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        outstanding = 1'b0;
        continue;
      end
      if (bus.ci_start) begin
        checkOutput("start_while_outstanding", 32'(outstanding), 32'd0);
        if (exp_ops.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_op: n=%0d dataa=%h, none queued", bus.ci_n, bus.ci_dataa);
        end else begin
          e = exp_ops.pop_front();
          checkOutput("ci_n", 32'(bus.ci_n), 32'(e.n));
          checkOutput("ci_dataa", bus.ci_dataa, e.dataa);
        end
        started.n = bus.ci_n;
        started.dataa = bus.ci_dataa;
        outstanding = !bus.ci_done;
      end else if (bus.ci_clk_en) begin
        checkOutput("ci_n_stable", 32'(bus.ci_n), 32'(started.n));
        checkOutput("ci_dataa_stable", bus.ci_dataa, started.dataa);
        if (bus.ci_done) outstanding = 1'b0;
      end else begin
        outstanding = 1'b0;
      end
      if (bus.crc_valid || bus.crc_error) begin
        valid_cyc = cyc;
        if (exp_res.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_result: valid=%0b error=%0b value=%h, none queued",
                   bus.crc_valid, bus.crc_error, bus.crc_value);
        end else begin
          r = exp_res.pop_front();
          checkOutput("result_is_error", 32'(bus.crc_error), 32'(r.is_err));
          checkOutput("result_valid", 32'(bus.crc_valid), 32'(!r.is_err));
          if (!r.is_err) checkOutput("crc_value", bus.crc_value, r.value);
        end
      end
    end
  end

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_ci_start"}, 32'(bus.ci_start), 32'd0);
    checkOutput({tag, "_ci_clk_en"}, 32'(bus.ci_clk_en), 32'd0);
    checkOutput({tag, "_ci_n"}, 32'(bus.ci_n), 32'd0);
    checkOutput({tag, "_ci_dataa"}, bus.ci_dataa, 32'd0);
    checkOutput({tag, "_crc_value"}, bus.crc_value, 32'd0);
    checkOutput({tag, "_crc_valid"}, 32'(bus.crc_valid), 32'd0);
    checkOutput({tag, "_crc_error"}, 32'(bus.crc_error), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin : main
    int guard;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
    #1;
    checkZeroOutputs("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] digits packet");
    expectDigits();
    sendDigits();
    waitIdle();

    $display("[TB] single byte 0x61");
    pushOp(CI_N_INIT, 32'h0);
    pushOp(CI_N_WR8, 32'h00000061);
    pushOp(CI_N_RD32, 32'h0);
    pushRes(1'b0, 32'hE8B7BE43);
    applyStimulus(8'h61, 1'b1, 1'b1);
    waitIdle();
    checkOutput("valid_latency", 32'(valid_cyc - last_acc), 32'd5);

    $display("[TB] three byte tail");
    pushOp(CI_N_INIT, 32'h0);
    pushOp(CI_N_WR16, 32'h00003231);
    pushOp(CI_N_WR8, 32'h00000033);
    pushOp(CI_N_RD32, 32'h0);
    pushRes(1'b0, 32'h884863D2);
    applyStimulus(8'h31, 1'b1, 1'b0);
    applyStimulus(8'h32, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b0, 1'b1);
    waitIdle();

    $display("[TB] slave stalls 3 cycles");
    stall_all = 3;
    expectDigits();
    sendDigits();
    waitIdle();

    $display("[TB] stall beyond timeout");
    stall_once = TMO + 1;
    pushOp(CI_N_INIT, 32'h0);
    pushRes(1'b1, 32'h0);
    applyStimulus(8'h61, 1'b1, 1'b1);
    waitIdle();
    stall_all = -1;
    checkOutput("idle_after_timeout", 32'(bus.busy), 32'd0);
    expectDigits();
    sendDigits();
    waitIdle();

    $display("[TB] stray byte, then sop mid-packet");
    applyStimulus(8'h77, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("stray_byte_dropped", 32'(bus.busy), 32'd0);
    pushOp(CI_N_INIT, 32'h0);
    expectDigits();
    applyStimulus(8'h41, 1'b1, 1'b0);
    applyStimulus(8'h42, 1'b0, 1'b0);
    sendDigits();
    waitIdle();

    $display("[TB] reset during WAIT");
    stall_once = 100;
    pushOp(CI_N_INIT, 32'h0);
    applyStimulus(8'h55, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("wait_clk_en", 32'(bus.ci_clk_en), 32'd1);
    checkOutput("wait_start", 32'(bus.ci_start), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    checkZeroOutputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("ops_after_reset", 32'(exp_ops.size()), 32'd0);
    expectDigits();
    sendDigits();
    waitIdle();

    repeat (3) @(negedge clk);
    checkOutput("ops_drained", 32'(exp_ops.size()), 32'd0);
    checkOutput("results_drained", 32'(exp_res.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/crc_ci_stream_master.md
# crc_ci_stream_master

Initiator side of the Nios II custom-instruction CRC interface. It consumes a byte-wide packet stream and issues the init, write and read custom-instruction opcodes the CRC custom-instruction slave expects. It presents one 32-bit CRC per packet, so hardware datapaths can checksum firmware or packet data without CPU involvement. It sits between a byte source (flash reader, SPI/UART receiver) and a dedicated CRC custom-instruction slave instance.

## Interface
- `DONE_TIMEOUT`, default 255: max cycles `ci_clk_en` stays high waiting for `ci_done` before aborting; range 1..255.
- `READ_N`, default 4: opcode used to read the result (4 = 32-bit CRC).
- `clk`  in  1  sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `in_data`  in  8  stream byte
- `in_valid`  in  1  byte valid
- `in_sop`  in  1  first byte of packet
- `in_eop`  in  1  last byte of packet
- `in_ready`  out  1  byte accepted when `in_valid & in_ready`
- `ci_n`  out  3  opcode to slave
- `ci_dataa`  out  32  operand to slave
- `ci_start`  out  1  one-cycle instruction start
- `ci_clk_en`  out  1  high from start until done
- `ci_done`  in  1  slave completion (may coincide with `ci_start`)
- `ci_result`  in  32  slave result, sampled when `ci_done`
- `crc_value`  out  32  last CRC; held until the next `crc_valid`
- `crc_valid`  out  1  one-cycle pulse, new `crc_value`
- `crc_error`  out  1  one-cycle pulse on done timeout
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, FILL, CMD, WAIT, FINISH.
- IDLE:
  - `in_ready`=1.
  - A beat without `in_sop` is dropped.
  - A beat with `in_sop` stores the byte in lane 0, sets count=1, queues INIT and goes to CMD.
- CMD:
  - `ci_start`=1 and `ci_clk_en`=1 with queued `ci_n`/`ci_dataa`; `in_ready`=0.
  - If `ci_done` is high in the same cycle, the op completes; otherwise go to WAIT.
- WAIT: `ci_clk_en`=1, `ci_start`=0; stay until `ci_done`.
- Op completion dispatch:
  - After INIT, or after a WR32 that was not last: go to FILL.
  - After the last write: queue n=`READ_N` and go to CMD.
  - After the read: latch `ci_result` into `crc_value` and go to FINISH.
- FILL: `in_ready`=1; byte k of the word goes to `ci_dataa[8k+7:8k]`, little-endian (first byte in the LSBs).
- Flush on the 4th byte or on `in_eop`, by count after the byte:
  - 4: n=3 (WR32).
  - 1: n=1 (WR8).
  - 2: n=2 (WR16).
  - 3: n=2 with bytes 0-1, then n=1 with byte 2 in `ci_dataa[7:0]`.
- Unused `ci_dataa` bytes are driven 0.
- FINISH: `crc_valid`=1 for one cycle, then go to IDLE.
- `in_sop` and `in_eop` on the same beat: single-byte packet, sequence INIT, WR8, READ.
- `in_sop` in FILL: the partial word is discarded, the new byte goes to lane 0, and INIT is re-issued. No `crc_valid` for the aborted packet.
- Timeout: a counter starts at `ci_start`. If `ci_done` has not arrived when it reaches `DONE_TIMEOUT`:
  - `ci_clk_en`=0 and `crc_error` pulses.
  - The packet is abandoned and the block returns to IDLE.
- Reset: all outputs 0 (`crc_value`=0, `ci_n`=0, `ci_dataa`=0), state IDLE. An in-flight instruction is abandoned; the next packet always re-initialises the slave via INIT.

## Timing
- `ci_start` is high exactly one cycle per instruction. It is never asserted while a previous instruction is outstanding.
- `ci_n` and `ci_dataa` are registered and stable from `ci_start` until `ci_done`.
- `ci_done` is honoured only while `ci_clk_en`=1 and ignored otherwise.
- Latency with a done-on-start write / done+1 read slave:
  - Single-byte packet accepted at T: INIT at T+1, WR8 at T+2, READ at T+3, done at T+4, `crc_valid` at T+5.
  - N-byte packet: one cycle per byte in FILL, plus one cycle per write, plus 3 cycles (read, done, FINISH).
- `in_ready` is combinational from state only (high in IDLE and FILL), never from `in_valid`.

## Structure
- Package `crc_ci_pkg` holds:
  - State enum.
  - Opcode constants CI_N_INIT=0, CI_N_WR8=1, CI_N_WR16=2, CI_N_WR32=3, CI_N_RD32=4.
  - Timeout counter width (8).
- One natural sub-module, `crc_ci_packer`: byte-lane packing, count and tail-split logic. It outputs the word, its opcode and a pending-second-write flag. The FSM and timeout stay in the top.

## Test plan
Benches use a slave model that asserts done with start for writes and one cycle later for reads, unless stated otherwise.
- "123456789" as one packet -> op sequence INIT, WR32, WR32, WR8; `crc_value`=0xCBF43926, single `crc_valid` pulse.
- Single byte 0x61 with sop+eop -> INIT, WR8 (`ci_dataa`=0x00000061), READ; `crc_value`=0xE8B7BE43, `crc_valid` exactly 5 cycles after the accept.
- 3-byte tail 0x31,0x32,0x33 -> WR16 with `ci_dataa`=0x00003231, then WR8 with 0x00000033; `crc_value`=0x884863D2.
- Slave stalling done by 3 cycles on every op, then one op stalled for `DONE_TIMEOUT`+1 cycles:
  - `ci_start` stays a single pulse and the stalled ops complete normally.
  - The over-long stall gives a `crc_error` pulse and IDLE, and the next "123456789" packet still gives 0xCBF43926.
- `in_sop` mid-packet after 2 bytes, then "123456789" -> no `crc_valid` for the aborted packet; result 0xCBF43926.
- `reset_n` low during WAIT -> all outputs 0 immediately; the next packet starts with INIT and yields the correct CRC.
